arm_pipelined_data_memory_stage: RTL and testbench
==================================================

# arm_pipelined_data_memory_stage

Memory-stage controller between the pipelined datapath's Execute→Memory register outputs (address, store data) and a multi-cycle external data bus with valid/ready request and valid-only response channels. Stores are posted into a 2-entry write buffer and retire without stalling unless the buffer is full. Loads drain the buffer, then issue a bus read and stall the pipeline until the read data is ready for the Memory→WriteBack register.

## Interface
- BusWidth, 32, data/address width
- i_CLK  in  1  clock, all state on rising edge
- i_RESET  in  1  asynchronous, active-high reset
- i_Mem_Read_Memory  in  1  load present in Memory stage
- i_Mem_Write_Memory  in  1  store present in Memory stage
- i_Data_Addr  in  BusWidth  byte address (ALU result, Memory stage)
- i_Write_Data  in  BusWidth  store data
- o_Read_Data  out  BusWidth  load data to Memory→WriteBack register
- o_Stall_Memory  out  1  to hazard unit; holds Memory stage and all upstream stages
- o_Bus_Req_Valid  out  1  bus request valid
- i_Bus_Req_Ready  in  1  bus accepts request
- o_Bus_Write  out  1  1 = write, 0 = read
- o_Bus_Addr  out  BusWidth  word address, bits [1:0] forced to 0
- o_Bus_WData  out  BusWidth  write data
- i_Bus_Resp_Valid  in  1  read data valid (reads only; writes have no response)
- i_Bus_RData  in  BusWidth  read data
- o_WB_Empty  out  1  write buffer empty

## Operation
- FSM states: IDLE, RD_REQ, RD_WAIT, RD_DONE.
- Write buffer: 2-entry FIFO of {addr, data}, count 0..2, 1-bit wrapping read/write pointers.
- Store accept: store accepted (pushed) in any cycle with i_Mem_Write_Memory=1 and o_Stall_Memory=0. If both read and write are asserted, the access is a store only.
- Bus priority: the buffer head is always presented first. o_Bus_Req_Valid=1, o_Bus_Write=1 whenever count>0 and state≠RD_REQ. Pop on Valid&Ready.
- The write-issue condition never holds in RD_REQ, because RD_REQ is entered only with the buffer empty.
- Store stall: o_Stall_Memory=1 for a store when count==2 and no pop occurs this cycle. Push and pop in the same full cycle are legal; count stays 2.
- Load path:
  - IDLE, load present, count==0: latch address into an address register, go to RD_REQ.
  - IDLE, load present, count>0: stay in IDLE and drain the buffer.
  - RD_REQ: Valid=1, Write=0, Addr=latched address. On Ready, go to RD_WAIT.
  - RD_WAIT: on i_Bus_Resp_Valid, capture i_Bus_RData into the data register and go to RD_DONE.
  - RD_DONE: go to IDLE unconditionally.
- Load stall: o_Stall_Memory=1 when a load is present and state≠RD_DONE. It is 0 in RD_DONE, so the pipeline advances and the WriteBack register samples o_Read_Data.
- o_Read_Data = data register. It holds its value until the next capture.
- i_Bus_Resp_Valid outside RD_WAIT is ignored.
- o_WB_Empty = (count==0).

## Timing
- Reset (asynchronous, immediate) values:
  - state=IDLE, count=0, pointers=0, data and address registers=0.
  - o_Read_Data=0, o_Bus_Req_Valid=0, o_Bus_Write=0, o_Bus_Addr=0, o_Bus_WData=0, o_Stall_Memory=0 (with no load/store present), o_WB_Empty=1.
- Reset mid-operation: buffered writes are discarded and any in-flight read is abandoned. A late response after reset is ignored.
- Store latency: 0 stall cycles when not full. The buffered write appears on the bus the cycle after the push (registered FIFO).
- Minimum load (buffer empty, Ready and Resp each on first opportunity):
  - load arrives cycle 0 (IDLE);
  - RD_REQ in cycle 1;
  - RD_WAIT in cycle 2 with response;
  - RD_DONE in cycle 3.
  - Result: stall high in cycles 0–2 (3 stall cycles), data sampled at the end of cycle 3.
- Each buffered write ahead of a load adds at least 1 cycle per entry. Bus Ready=0 and response delay extend the stall cycle-for-cycle.
- All outputs except o_Stall_Memory are driven from registers or from state/FIFO decode. o_Stall_Memory is combinational from the inputs, state and count.

## Test plan
- Reset with Req_Ready=1 idle → all outputs at reset values, o_WB_Empty=1. Assert i_RESET while in RD_WAIT → state IDLE immediately, and a Resp_Valid 1 cycle later does not change o_Read_Data.
- Single store addr 0x100, data 0xDEADBEEF, Ready=1 → no stall. Next cycle: Valid=1, Write=1, Addr=0x100, WData=0xDEADBEEF. The cycle after: o_WB_Empty=1.
- Three back-to-back stores, Ready=0 → third store stalls (count==2). Raise Ready → pop and push in the same cycle, stall drops, writes emitted in order addr0, addr1, addr2.
- Load at 0x203 with Ready=1 and response 0x12345678 on the first RD_WAIT cycle → o_Bus_Addr=0x200, Write=0, exactly 3 stall cycles, o_Read_Data=0x12345678 in RD_DONE.
- Store 0x40←5 immediately followed by load 0x40, Ready=1 → the write issues before the read request, and the load stall covers the drain cycle.
- Load with Ready held 0 for 4 cycles and response 2 cycles later → stall lasts 4+1+2 cycles, with no spurious request after RD_DONE.

Source files
------------

// File: rtl/arm_pipelined_data_memory_stage.sv
// Memory-stage controller: posts stores into a 2-entry write buffer and runs
// loads as a stalled read transaction on a valid/ready bus with a valid-only response.
module arm_pipelined_data_memory_stage #(
  parameter int BusWidth = 32
) (
  input  logic                i_CLK,
  input  logic                i_RESET,
  input  logic                i_Mem_Read_Memory,
  input  logic                i_Mem_Write_Memory,
  input  logic [BusWidth-1:0] i_Data_Addr,
  input  logic [BusWidth-1:0] i_Write_Data,
  output logic [BusWidth-1:0] o_Read_Data,
  output logic                o_Stall_Memory,
  output logic                o_Bus_Req_Valid,
  input  logic                i_Bus_Req_Ready,
  output logic                o_Bus_Write,
  output logic [BusWidth-1:0] o_Bus_Addr,
  output logic [BusWidth-1:0] o_Bus_WData,
  input  logic                i_Bus_Resp_Valid,
  input  logic [BusWidth-1:0] i_Bus_RData,
  output logic                o_WB_Empty
);

  typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, RD_DONE} state_t;

  state_t                       state;
  logic [1:0][BusWidth-1:0]     wb_addr, wb_data;
  logic                         wr_ptr, rd_ptr;
  logic [1:0]                   count;
  logic [BusWidth-1:0]          addr_reg, data_reg;

  logic is_store, is_load, wr_issue, rd_issue, push, pop;

  // A simultaneous read+write request is treated purely as a store.
  assign is_store = i_Mem_Write_Memory;
  assign is_load  = i_Mem_Read_Memory & ~i_Mem_Write_Memory;

  assign wr_issue = (count != 2'd0) && (state != RD_REQ);
  assign rd_issue = (state == RD_REQ);
  assign pop      = wr_issue & i_Bus_Req_Ready;
  assign push     = is_store & ~o_Stall_Memory;

  assign o_Stall_Memory = (is_store && count == 2'd2 && !pop) ||
                          (is_load  && state != RD_DONE);

  assign o_Bus_Req_Valid = wr_issue | rd_issue;
  assign o_Bus_Write     = wr_issue;
  assign o_Bus_Addr      = rd_issue ? {addr_reg[BusWidth-1:2], 2'b00} :
                           wr_issue ? {wb_addr[rd_ptr][BusWidth-1:2], 2'b00} : '0;
  assign o_Bus_WData     = wr_issue ? wb_data[rd_ptr] : '0;
  assign o_Read_Data     = data_reg;
  assign o_WB_Empty      = (count == 2'd0);

  // Buffer storage needs no reset: it is only visible through wr_issue.
  always_ff @(posedge i_CLK) begin
    if (push) begin
      wb_addr[wr_ptr] <= i_Data_Addr;
      wb_data[wr_ptr] <= i_Write_Data;
    end
  end

  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      if (push && !pop)      count <= count + 2'd1;
      else if (pop && !push) count <= count - 2'd1;
    end
  end

  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      state    <= IDLE;
      addr_reg <= '0;
      data_reg <= '0;
    end else begin
      case (state)
        IDLE:    if (is_load && count == 2'd0) begin
                   addr_reg <= i_Data_Addr;
                   state    <= RD_REQ;
                 end
        RD_REQ:  if (i_Bus_Req_Ready) state <= RD_WAIT;
        RD_WAIT: if (i_Bus_Resp_Valid) begin
                   data_reg <= i_Bus_RData;
                   state    <= RD_DONE;
                 end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arm_pipelined_data_memory_stage.sv
// Directed bench: a transaction-level model checks every cycle, hand literals pin key points.
module tb_arm_pipelined_data_memory_stage;

  logic        clk = 1'b0, rst = 1'b1;
  logic        rd = 0, wr = 0, rdy = 1, rv = 0;
  logic [31:0] addr = 0, wd = 0, rdat = 0;
  logic [31:0] o_rdata, o_baddr, o_bwdata;
  logic        o_stall, o_bvalid, o_bwrite, o_empty;

  arm_pipelined_data_memory_stage #(.BusWidth(32)) dut (
    .i_CLK(clk), .i_RESET(rst),
    .i_Mem_Read_Memory(rd), .i_Mem_Write_Memory(wr),
    .i_Data_Addr(addr), .i_Write_Data(wd),
    .o_Read_Data(o_rdata), .o_Stall_Memory(o_stall),
    .o_Bus_Req_Valid(o_bvalid), .i_Bus_Req_Ready(rdy),
    .o_Bus_Write(o_bwrite), .o_Bus_Addr(o_baddr), .o_Bus_WData(o_bwdata),
    .i_Bus_Resp_Valid(rv), .i_Bus_RData(rdat), .o_WB_Empty(o_empty)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pending writes in a queue; a load goes none -> requesting -> waiting -> done.
  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
  wr_t         wq[$];
  int          lphase = 0;
  logic [31:0] laddr = 0, mdata = 0;

  always @(negedge clk) begin
    logic        wv, ev, pop, st, ld, estall;
    logic [31:0] ea, ewd;
    int          sz;
    if (rst) begin
      wq.delete(); lphase = 0; laddr = 0; mdata = 0;
    end
    sz  = wq.size();
    wv  = (sz > 0) && (lphase != 1);
    ev  = wv || (lphase == 1);
    ea  = (lphase == 1) ? (laddr & ~32'h3) : wv ? (wq[0].a & ~32'h3) : 32'h0;
    ewd = wv ? wq[0].d : 32'h0;
    pop = wv && rdy;
    st  = wr;
    ld  = rd && !wr;
    estall = (st && sz == 2 && !pop) || (ld && lphase != 3);
    check("m_valid", {31'h0, o_bvalid}, {31'h0, ev});
    check("m_write", {31'h0, o_bwrite}, {31'h0, wv});
    check("m_addr",  o_baddr,  ea);
    check("m_wdata", o_bwdata, ewd);
    check("m_stall", {31'h0, o_stall}, {31'h0, estall});
    check("m_empty", {31'h0, o_empty}, {31'h0, sz == 0});
    check("m_rdata", o_rdata, mdata);
    if (!rst) begin
      if (pop) void'(wq.pop_front());
      if (st && !estall) wq.push_back('{a: addr, d: wd});
      case (lphase)
        0: if (ld && sz == 0) begin lphase = 1; laddr = addr; end
        1: if (rdy) lphase = 2;
        2: if (rv) begin lphase = 3; mdata = rdat; end
        default: lphase = 0;
      endcase
    end
  end

  int ns;

  task automatic step(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic ready, input logic resp, input logic [31:0] rd_data);
    @(posedge clk); #1;
    rd = r; wr = w; addr = a; wd = d; rdy = ready; rv = resp; rdat = rd_data;
    @(negedge clk);
    ns += int'(o_stall);
  endtask

  initial begin
    // reset with ready high and nothing present
    @(negedge clk);
    check("rst_valid", {31'h0, o_bvalid}, 32'h0);
    check("rst_write", {31'h0, o_bwrite}, 32'h0);
    check("rst_addr", o_baddr, 32'h0);
    check("rst_wdata", o_bwdata, 32'h0);
    check("rst_rdata", o_rdata, 32'h0);
    check("rst_stall", {31'h0, o_stall}, 32'h0);
    check("rst_empty", {31'h0, o_empty}, 32'h1);
    @(posedge clk); #1; rst = 0;

    // single store
    step(0, 1, 32'h100, 32'hDEADBEEF, 1, 0, 0);
    check("st1_stall", {31'h0, o_stall}, 32'h0);
    step(0, 0, 0, 0, 1, 0, 0);
    check("st1_valid", {31'h0, o_bvalid}, 32'h1);
    check("st1_write", {31'h0, o_bwrite}, 32'h1);
    check("st1_addr", o_baddr, 32'h100);
    check("st1_wdata", o_bwdata, 32'hDEADBEEF);
    step(0, 0, 0, 0, 1, 0, 0);
    check("st1_empty", {31'h0, o_empty}, 32'h1);

    // three stores into a blocked bus, then release
    step(0, 1, 32'h10, 32'h1, 0, 0, 0);
    step(0, 1, 32'h14, 32'h2, 0, 0, 0);
    step(0, 1, 32'h18, 32'h3, 0, 0, 0);
    check("full_stall", {31'h0, o_stall}, 32'h1);
    step(0, 1, 32'h18, 32'h3, 1, 0, 0);
    check("full_pushpop_stall", {31'h0, o_stall}, 32'h0);
    check("order0", o_baddr, 32'h10);
    step(0, 0, 0, 0, 1, 0, 0);
    check("order1", o_baddr, 32'h14);
    step(0, 0, 0, 0, 1, 0, 0);
    check("order2", o_baddr, 32'h18);
    check("order2_wdata", o_bwdata, 32'h3);
    step(0, 0, 0, 0, 1, 1, 32'hBAD0BAD0);  // stray response while idle
    check("drain_empty", {31'h0, o_empty}, 32'h1);

    // minimum load at an unaligned address
    ns = 0;
    step(1, 0, 32'h203, 0, 1, 0, 0);
    step(1, 0, 32'h203, 0, 1, 0, 0);
    check("ld_addr", o_baddr, 32'h200);
    check("ld_write", {31'h0, o_bwrite}, 32'h0);
    step(1, 0, 32'h203, 0, 1, 1, 32'h12345678);
    step(1, 0, 32'h203, 0, 1, 0, 0);
    check("ld_done_stall", {31'h0, o_stall}, 32'h0);
    check("ld_rdata", o_rdata, 32'h12345678);
    check("ld_nstall", ns, 3);
    step(0, 0, 0, 0, 1, 0, 0);

    // store then load to the same word: write drains first
    step(0, 1, 32'h40, 32'h5, 1, 0, 0);
    ns = 0;
    step(1, 0, 32'h40, 0, 1, 0, 0);
    check("sl_write_first", {31'h0, o_bwrite}, 32'h1);
    check("sl_wdata", o_bwdata, 32'h5);
    step(1, 0, 32'h40, 0, 1, 0, 0);
    step(1, 0, 32'h40, 0, 1, 0, 0);
    check("sl_read_req", {31'h0, o_bvalid & ~o_bwrite}, 32'h1);
    step(1, 0, 32'h40, 0, 1, 1, 32'hCAFE0005);
    step(1, 0, 32'h40, 0, 1, 0, 0);
    check("sl_rdata", o_rdata, 32'hCAFE0005);
    check("sl_nstall", ns, 4);
    step(0, 0, 0, 0, 1, 0, 0);

    // slow bus: ready low 4 cycles, response on second wait cycle
    ns = 0;
    for (int i = 0; i < 4; i++) step(1, 0, 32'h80, 0, 0, 0, 0);
    step(1, 0, 32'h80, 0, 1, 0, 0);
    step(1, 0, 32'h80, 0, 1, 0, 0);
    step(1, 0, 32'h80, 0, 1, 1, 32'hA5A50001);
    step(1, 0, 32'h80, 0, 1, 0, 0);
    check("slow_rdata", o_rdata, 32'hA5A50001);
    check("slow_nstall", ns, 7);
    step(0, 0, 0, 0, 1, 0, 0);
    check("slow_no_spurious", {31'h0, o_bvalid}, 32'h0);

    // read+write together is a store only
    step(1, 1, 32'h500, 32'h7, 1, 0, 0);
    check("rw_stall", {31'h0, o_stall}, 32'h0);
    step(0, 0, 0, 0, 1, 0, 0);
    check("rw_write", {31'h0, o_bwrite}, 32'h1);
    check("rw_addr", o_baddr, 32'h500);
    step(0, 0, 0, 0, 1, 0, 0);

    // reset while waiting for a read response
    step(1, 0, 32'h300, 0, 1, 0, 0);
    step(1, 0, 32'h300, 0, 1, 0, 0);
    step(1, 0, 32'h300, 0, 1, 0, 0);
    @(posedge clk); #1; rst = 1; rd = 0;
    @(negedge clk);
    check("mid_rst_valid", {31'h0, o_bvalid}, 32'h0);
    check("mid_rst_rdata", o_rdata, 32'h0);
    @(posedge clk); #1; rst = 0; rv = 1; rdat = 32'hBAD;
    @(negedge clk);
    check("late_resp_ignored", o_rdata, 32'h0);
    step(0, 0, 0, 0, 1, 0, 0);
    check("late_resp_idle", {31'h0, o_bvalid}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
